// File: rtl/ifm_pingpong_buffer_if.sv
// Producer/consumer signal bundle for the ping/pong feature-map buffer.
// The buffer uses the slave modport; the producer/consumer side uses master.
interface ifm_pingpong_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned SEL_BITS   = 2,
    parameter int unsigned MAP_BITS   = 3
);
    logic                  start_from_previous;
    logic                  end_to_previous;
    logic                  ifm_enable_write;
    logic                  ifm_enable_read;
    logic [ADDR_BITS-1:0]  ifm_address_write;
    logic [ADDR_BITS-1:0]  ifm_address_read;
    logic [SEL_BITS-1:0]   ifm_sel;
    logic [DATA_WIDTH-1:0] data_in_prev1;
    logic [DATA_WIDTH-1:0] data_in_prev2;
    logic [DATA_WIDTH-1:0] data_in_prev3;
    logic [DATA_WIDTH-1:0] data_out_prev1;
    logic [DATA_WIDTH-1:0] data_out_prev2;
    logic [DATA_WIDTH-1:0] data_out_prev3;
    logic                  wr_stall;
    logic                  start_to_next;
    logic                  end_from_next;
    logic                  rd_enable_next;
    logic [MAP_BITS-1:0]   rd_map_next;
    logic [ADDR_BITS-1:0]  rd_address_next;
    logic [DATA_WIDTH-1:0] data_out_next;
    logic                  overflow_err;
    logic                  underflow_err;

    modport slave (
        input  start_from_previous, ifm_enable_write, ifm_enable_read,
        input  ifm_address_write, ifm_address_read, ifm_sel,
        input  data_in_prev1, data_in_prev2, data_in_prev3,
        input  end_from_next, rd_enable_next, rd_map_next, rd_address_next,
        output end_to_previous, data_out_prev1, data_out_prev2, data_out_prev3,
        output wr_stall, start_to_next, data_out_next, overflow_err, underflow_err
    );

    modport master (
        output start_from_previous, ifm_enable_write, ifm_enable_read,
        output ifm_address_write, ifm_address_read, ifm_sel,
        output data_in_prev1, data_in_prev2, data_in_prev3,
        output end_from_next, rd_enable_next, rd_map_next, rd_address_next,
        input  end_to_previous, data_out_prev1, data_out_prev2, data_out_prev3,
        input  wr_stall, start_to_next, data_out_next, overflow_err, underflow_err
    );
endinterface

// File: rtl/ifm_pingpong_buffer.sv
// Two-bank feature-map buffer: the producer fills the write bank while the consumer
// drains the read bank; banks cycle EMPTY -> FULL -> READING -> EMPTY.
module ifm_pingpong_buffer #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned IFM_SIZE        = 28,
    parameter int unsigned NUMBER_OF_IFM   = 6,
    parameter int unsigned NUMBER_OF_UNITS = 3,
    parameter int unsigned ADDR_BITS       = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int unsigned SEL_BITS        = $clog2(NUMBER_OF_IFM / NUMBER_OF_UNITS + 1),
    parameter int unsigned MAP_BITS        = $clog2(NUMBER_OF_IFM)
) (
    input  logic               clk,
    input  logic               reset,
    ifm_pingpong_buffer_if.slave bus
);
    localparam int unsigned MAP_WORDS = IFM_SIZE * IFM_SIZE;
    localparam int unsigned LANE_BITS = $clog2((2 ** SEL_BITS) * NUMBER_OF_UNITS);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_READING = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [2][NUMBER_OF_IFM][MAP_WORDS];

    logic [1:0]            r_state [2];
    logic [1:0]            w_state_d [2];
    logic                  r_wr_bank, w_wr_bank_d;
    logic                  r_rd_bank, w_rd_bank_d;
    logic                  r_wr_stall;
    logic                  r_start_to_next, r_end_to_previous;
    logic                  r_overflow, r_underflow;
    logic                  w_start_pulse, w_end_pulse, w_ovf_set, w_unf_set;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] r_prev [NUMBER_OF_UNITS];
    logic [DATA_WIDTH-1:0] r_next;
    logic [DATA_WIDTH-1:0] w_din [NUMBER_OF_UNITS];
    logic [LANE_BITS-1:0]  w_lane_map [NUMBER_OF_UNITS];
    logic                  w_lane_ok [NUMBER_OF_UNITS];

    assign w_din[0] = bus.data_in_prev1;
    assign w_din[1] = bus.data_in_prev2;
    assign w_din[2] = bus.data_in_prev3;

    // Lanes that land past the last map are masked for both write and read-back.
    always_comb begin
        for (int u = 0; u < NUMBER_OF_UNITS; u++) begin
            w_lane_map[u] = LANE_BITS'(bus.ifm_sel) * LANE_BITS'(NUMBER_OF_UNITS)
                            + LANE_BITS'(u);
            w_lane_ok[u]  = w_lane_map[u] < LANE_BITS'(NUMBER_OF_IFM);
        end
    end

    assign w_wr_en = reset && bus.ifm_enable_write && (r_state[r_wr_bank] == ST_EMPTY);

    always_comb begin
        w_state_d     = r_state;
        w_wr_bank_d   = r_wr_bank;
        w_rd_bank_d   = r_rd_bank;
        w_ovf_set     = 1'b0;
        w_unf_set     = 1'b0;
        w_end_pulse   = 1'b0;
        w_start_pulse = 1'b0;
        if (bus.start_from_previous) begin
            if (r_state[r_wr_bank] == ST_EMPTY) begin
                w_state_d[r_wr_bank] = ST_FULL;
                w_wr_bank_d          = ~r_wr_bank;
            end else begin
                w_ovf_set = 1'b1;
            end
        end
        if (bus.ifm_enable_write && (r_state[r_wr_bank] != ST_EMPTY)) begin
            w_ovf_set = 1'b1;
        end
        if (bus.end_from_next) begin
            if (r_state[r_rd_bank] == ST_READING) begin
                w_state_d[r_rd_bank] = ST_EMPTY;
                w_rd_bank_d          = ~r_rd_bank;
                w_end_pulse          = 1'b1;
            end else begin
                w_unf_set = 1'b1;
            end
        end
        // Only the rd bank can be READING, so a FULL rd bank implies an idle consumer.
        if (w_state_d[w_rd_bank_d] == ST_FULL) begin
            w_state_d[w_rd_bank_d] = ST_READING;
            w_start_pulse          = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state[0]        <= ST_EMPTY;
            r_state[1]        <= ST_EMPTY;
            r_wr_bank         <= 1'b0;
            r_rd_bank         <= 1'b0;
            r_wr_stall        <= 1'b0;
            r_start_to_next   <= 1'b0;
            r_end_to_previous <= 1'b0;
            r_overflow        <= 1'b0;
            r_underflow       <= 1'b0;
        end else begin
            r_state           <= w_state_d;
            r_wr_bank         <= w_wr_bank_d;
            r_rd_bank         <= w_rd_bank_d;
            r_wr_stall        <= (r_state[r_wr_bank] != ST_EMPTY);
            r_start_to_next   <= w_start_pulse;
            r_end_to_previous <= w_end_pulse;
            r_overflow        <= r_overflow | w_ovf_set;
            r_underflow       <= r_underflow | w_unf_set;
        end
    end

    always_ff @(posedge clk) begin
        for (int u = 0; u < NUMBER_OF_UNITS; u++) begin
            if (w_wr_en && w_lane_ok[u]) begin
                r_mem[r_wr_bank][w_lane_map[u][MAP_BITS-1:0]][bus.ifm_address_write] <= w_din[u];
            end
        end
    end

    // Read ports sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int u = 0; u < NUMBER_OF_UNITS; u++) begin
                r_prev[u] <= '0;
            end
            r_next <= '0;
        end else begin
            for (int u = 0; u < NUMBER_OF_UNITS; u++) begin
                if (bus.ifm_enable_read && w_lane_ok[u]) begin
                    r_prev[u] <= r_mem[r_wr_bank][w_lane_map[u][MAP_BITS-1:0]]
                                      [bus.ifm_address_read];
                end
            end
            if (bus.rd_enable_next) begin
                r_next <= r_mem[r_rd_bank][bus.rd_map_next][bus.rd_address_next];
            end
        end
    end

    assign bus.data_out_prev1  = r_prev[0];
    assign bus.data_out_prev2  = r_prev[1];
    assign bus.data_out_prev3  = r_prev[2];
    assign bus.data_out_next   = r_next;
    assign bus.wr_stall        = r_wr_stall;
    assign bus.start_to_next   = r_start_to_next;
    assign bus.end_to_previous = r_end_to_previous;
    assign bus.overflow_err    = r_overflow;
    assign bus.underflow_err   = r_underflow;
endmodule
